// File: rtl/sm_imem_pkg.sv
// Shared types and constants for the per-node runtime-loadable instruction memory.
package sm_imem_pkg;

  localparam int NODE_ID_W = 8;

  // RV32I "addi x0, x0, 0", returned for faulting fetches
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef logic [0:0] state_t;
  localparam state_t RUN  = 1'b0;
  localparam state_t LOAD = 1'b1;

  // Which source currently drives imem_rdata
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_NOP  = 2'd1,
    SRC_RAM  = 2'd2
  } rd_src_e;

endpackage

// File: rtl/sm_imem_if.sv
// Fetch port and program-load stream of sm_imem bundled as one interface.
interface sm_imem_if #(
  parameter int ADDR_W = 7
);
  // Load stream: a word transfers on every rising edge where ld_valid && ld_ready
  // are both high; ld_data must be stable while ld_valid is high; ld_ready does
  // not depend on ld_valid.
  logic                               imem_req;
  logic [31:0]                        imem_addr;
  logic [31:0]                        imem_rdata;
  logic                               imem_valid;
  logic                               imem_err;
  logic                               core_hold;
  logic                               ld_start;
  logic [ADDR_W-1:0]                  ld_base;
  logic [ADDR_W:0]                    ld_len;
  logic                               ld_valid;
  logic [31:0]                        ld_data;
  logic                               ld_ready;
  logic                               ld_done;
  logic [sm_imem_pkg::NODE_ID_W-1:0]  ld_node_id;

  modport master (
    output imem_req, imem_addr, ld_start, ld_base, ld_len, ld_valid, ld_data,
    input  imem_rdata, imem_valid, imem_err, core_hold, ld_ready, ld_done, ld_node_id
  );

  modport slave (
    input  imem_req, imem_addr, ld_start, ld_base, ld_len, ld_valid, ld_data,
    output imem_rdata, imem_valid, imem_err, core_hold, ld_ready, ld_done, ld_node_id
  );

endinterface

// File: rtl/sm_imem_ram.sv
// DEPTH x 32 simple dual-port RAM: synchronous write, registered read, no reset.
module sm_imem_ram #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // rdata only moves on a read, so it holds between fetches
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sm_imem.sv
// Per-core instruction memory: 1-cycle fetch port plus a streaming program loader
// that holds the core while its image is being replaced.
module sm_imem
  import sm_imem_pkg::*;
#(
  parameter int          ADDR_W    = 7,
  parameter int          NODE_ID   = 0,
  parameter bit          INIT_HALT = 1'b1,
  parameter logic [31:0] NOP_WORD  = NOP
) (
  input  logic   clk,
  input  logic   rst_n,
  sm_imem_if.slave bus,
  output state_t dbg_state
);

  localparam int              DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   rem;
  logic              booted;
  logic              done_q;
  logic              valid_q;
  rd_src_e           src_q;
  logic [31:0]       ram_rdata;

  logic              start_ok;
  logic [ADDR_W:0]   len_clamped;
  logic              wr_fire;
  logic              fetch_ok;
  logic              fault;
  logic              rd_en;

  assign start_ok    = (state == RUN) && bus.ld_start;
  assign len_clamped = (bus.ld_len > DEPTH_L) ? DEPTH_L : bus.ld_len;
  assign wr_fire     = (state == LOAD) && bus.ld_valid;
  assign fetch_ok    = (state == RUN) && bus.imem_req;
  assign fault       = (|bus.imem_addr[1:0]) || (|bus.imem_addr[31:ADDR_W+2]);
  assign rd_en       = fetch_ok && !fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      ptr    <= '0;
      rem    <= '0;
      booted <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        RUN: begin
          if (start_ok) begin
            if (len_clamped == '0) begin
              done_q <= 1'b1;
              booted <= 1'b1;
            end else begin
              state <= LOAD;
              ptr   <= bus.ld_base;
              rem   <= len_clamped;
            end
          end
        end
        default: begin
          // ptr wraps naturally past DEPTH-1 back to 0
          if (wr_fire) begin
            ptr <= ptr + 1'b1;
            rem <= rem - ONE_L;
            if (rem == ONE_L) begin
              state  <= RUN;
              done_q <= 1'b1;
              booted <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      src_q   <= SRC_ZERO;
    end else begin
      valid_q <= fetch_ok;
      if (fetch_ok) src_q <= fault ? SRC_NOP : SRC_RAM;
    end
  end

  sm_imem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (ptr),
    .wdata (bus.ld_data),
    .re    (rd_en),
    .raddr (bus.imem_addr[ADDR_W+1:2]),
    .rdata (ram_rdata)
  );

  always_comb begin
    bus.imem_rdata = '0;
    case (src_q)
      SRC_NOP: bus.imem_rdata = NOP_WORD;
      SRC_RAM: bus.imem_rdata = ram_rdata;
      default: bus.imem_rdata = '0;
    endcase
  end

  assign bus.imem_valid = valid_q;
  assign bus.imem_err   = valid_q && (src_q == SRC_NOP);
  assign bus.core_hold  = (state == LOAD) || (INIT_HALT && !booted);
  assign bus.ld_ready   = (state == LOAD);
  assign bus.ld_done    = done_q;
  assign bus.ld_node_id = NODE_ID_W'(NODE_ID);
  assign dbg_state      = state;

endmodule

// File: tb/tb_sm_imem.sv
// Directed + randomized bench for sm_imem against an array model of the program image.
module tb_sm_imem;
  import sm_imem_pkg::*;

  localparam int          AW      = 7;
  localparam int          DEPTH   = 2**AW;
  localparam int          W       = 66;   // {due[31:0], chk_data, err, data[31:0]}
  localparam logic [31:0] NOP_EXP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  state_t      dbg_state;
  int unsigned cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sm_imem_if #(.ADDR_W(AW)) bus ();

  sm_imem #(
    .ADDR_W   (AW),
    .NODE_ID  (5),
    .INIT_HALT(1'b1),
    .NOP_WORD (NOP_EXP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // ---------------- model / scoreboard ----------------
  int          vectors     = 0;
  int          miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0] model_mem [DEPTH];
  bit          model_known [DEPTH];
  bit          model_booted;
  logic [31:0] last_exp;
  bit          last_known;
  logic [31:0] ld_words[$];
  logic [W-1:0] mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected response to a fetch, due on the next cycle
  function automatic logic [W-1:0] expect_fetch(input logic [31:0] a);
    int idx;
    if ((a % 4) != 0 || a >= DEPTH * 4)
      return {32'(cyc + 1), 1'b1, 1'b1, NOP_EXP};
    idx = int'(a / 4);
    return {32'(cyc + 1), model_known[idx], 1'b0, model_mem[idx]};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0][65:34] == cyc) begin
        mon_e = exp_q.pop_front();
        chk("fetch_valid", 32'(bus.imem_valid), 32'd1);
        chk("fetch_err", 32'(bus.imem_err), 32'(mon_e[32]));
        if (mon_e[33]) chk("fetch_rdata", bus.imem_rdata, mon_e[31:0]);
        last_exp   = mon_e[31:0];
        last_known = mon_e[33];
      end else begin
        chk("idle_valid", 32'(bus.imem_valid), 32'd0);
        if (last_known) chk("hold_rdata", bus.imem_rdata, last_exp);
      end
    end
  end

  // ---------------- driver tasks (enter/leave 1 time unit after a posedge) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    bus.imem_req  = 1'b1;
    bus.imem_addr = a;
    exp_q.push_back(expect_fetch(a));
    tick();
    bus.imem_req = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    exp_q.delete();
    model_booted = 1'b0;
    last_exp     = '0;
    last_known   = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.ld_ready), 32'd0);
    chk("rst_done", 32'(bus.ld_done), 32'd0);
    chk("rst_valid", 32'(bus.imem_valid), 32'd0);
    chk("rst_err", 32'(bus.imem_err), 32'd0);
    chk("rst_rdata", bus.imem_rdata, 32'd0);
    chk("rst_hold", 32'(bus.core_hold), 32'd1);
    chk("rst_state", 32'(dbg_state), 32'(RUN));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic fill_words(input int n);
    ld_words.delete();
    for (int i = 0; i < n; i++) ld_words.push_back($urandom);
  endtask

  task automatic do_load(input int base, input int len, input int nsend, input int stall_at,
                         input bit fetch_same, input logic [31:0] faddr, input bit extra_start);
    int eff;
    int ptr;
    eff = (len > DEPTH) ? DEPTH : len;
    ptr = base;
    bus.ld_start = 1'b1;
    bus.ld_base  = AW'(base);
    bus.ld_len   = (AW+1)'(len);
    if (fetch_same) begin
      bus.imem_req  = 1'b1;
      bus.imem_addr = faddr;
      exp_q.push_back(expect_fetch(faddr));
    end
    tick();
    bus.ld_start = 1'b0;
    bus.imem_req = 1'b0;
    if (eff == 0) begin
      model_booted = 1'b1;
      chk("len0_done", 32'(bus.ld_done), 32'd1);
      chk("len0_ready", 32'(bus.ld_ready), 32'd0);
      chk("len0_hold", 32'(bus.core_hold), 32'(!model_booted));
      tick();
      chk("len0_done_pulse", 32'(bus.ld_done), 32'd0);
      chk("len0_ready2", 32'(bus.ld_ready), 32'd0);
      return;
    end
    chk("load_hold", 32'(bus.core_hold), 32'd1);
    chk("load_state", 32'(dbg_state), 32'(LOAD));
    for (int i = 0; i < nsend; i++) begin
      if (i == stall_at) begin
        // host stalls; fetches issued meanwhile must be dropped
        bus.ld_valid  = 1'b0;
        bus.imem_req  = 1'b1;
        bus.imem_addr = 32'h0;
        tick();
        tick();
        bus.imem_req = 1'b0;
      end
      if (extra_start && i == 3) begin
        bus.ld_start = 1'b1;
        bus.ld_base  = '0;
        bus.ld_len   = (AW+1)'(2);
      end
      bus.ld_valid = 1'b1;
      bus.ld_data  = ld_words[i];
      chk("ld_ready", 32'(bus.ld_ready), 32'd1);
      chk("mid_done", 32'(bus.ld_done), 32'd0);
      tick();
      bus.ld_start = 1'b0;
      model_mem[ptr]   = ld_words[i];
      model_known[ptr] = 1'b1;
      ptr = (ptr + 1) % DEPTH;
    end
    if (nsend == eff) begin
      model_booted = 1'b1;
      chk("ld_done", 32'(bus.ld_done), 32'd1);
      chk("done_hold", 32'(bus.core_hold), 32'(!model_booted));
      chk("done_ready", 32'(bus.ld_ready), 32'd0);
      tick();
      chk("ld_done_pulse", 32'(bus.ld_done), 32'd0);
      bus.ld_valid = 1'b0;
    end
  endtask

  task automatic random_fetches(input int n);
    int idx;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 9))
        0: fetch({$urandom_range(0, DEPTH-1), 2'($urandom_range(1, 3))} + 32'h0);
        1: fetch(32'(DEPTH * 4) + ($urandom_range(0, 1000) * 4));
        default: begin
          idx = 0;
          for (int t = 0; t < 20; t++) begin
            idx = $urandom_range(0, DEPTH-1);
            if (model_known[idx]) break;
          end
          if (!model_known[idx]) idx = 0;
          fetch(32'(idx * 4));
        end
      endcase
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int len;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i]   = '0;
      model_known[i] = 1'b0;
    end
    bus.imem_req  = 1'b0;
    bus.imem_addr = '0;
    bus.ld_start  = 1'b0;
    bus.ld_base   = '0;
    bus.ld_len    = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    #2;
    apply_reset();
    chk("node_id", 32'(bus.ld_node_id), 32'd5);

    // fetch served while held at boot; hold persists
    fetch(32'h0);
    tick();
    chk("hold_before_load", 32'(bus.core_hold), 32'd1);

    // first program with a 2-cycle host stall after word 2
    ld_words = '{32'h61400293, 32'h08000313, 32'h00532023, 32'h00032383, 32'h00000063};
    do_load(0, 5, 5, 2, 1'b0, 32'h0, 1'b0);
    fetch(32'h0C);
    fetch(32'h00);
    fetch(32'h10);
    tick();

    // wrap-around past the top word
    ld_words = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
    do_load(126, 4, 4, -1, 1'b0, 32'h0, 1'b0);
    fetch(32'h1F8);
    fetch(32'h1FC);
    fetch(32'h000);
    fetch(32'h004);

    // faulting fetches
    fetch(32'h202);
    fetch(32'h200);
    fetch(32'h8000_0000);
    tick();

    // empty load, then len-8 load with an ignored restart and a same-cycle fetch
    do_load(0, 0, 0, -1, 1'b0, 32'h0, 1'b0);
    fill_words(8);
    do_load(0, 8, 8, 5, 1'b1, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) fetch(32'(i * 4));
    tick();

    // reset in the middle of a load
    fill_words(6);
    do_load(20, 6, 3, -1, 1'b0, 32'h0, 1'b0);
    apply_reset();
    bus.ld_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("no_done_after_rst", 32'(bus.ld_done), 32'd0);
      chk("held_after_rst", 32'(bus.core_hold), 32'd1);
      tick();
    end
    do_load(0, 0, 0, -1, 1'b0, 32'h0, 1'b0);
    for (int i = 19; i < 24; i++) fetch(32'(i * 4));
    tick();

    // randomized loads and fetches
    for (int r = 0; r < 5; r++) begin
      base = $urandom_range(0, DEPTH-1);
      len  = $urandom_range(1, 24);
      fill_words(len);
      do_load(base, len, len, $urandom_range(0, len), 1'b0, 32'h0, 1'b0);
      random_fetches(8);
      tick();
    end

    // oversize length clamps to a full image
    fill_words(DEPTH);
    do_load($urandom_range(0, DEPTH-1), 200, DEPTH, $urandom_range(0, DEPTH-1), 1'b0, 32'h0, 1'b0);
    random_fetches(16);
    repeat (3) tick();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sm_imem.md
Name: sm_imem

Overview:
- Per-node instruction memory for the multicore schoolRISCV array.
- Instruction memory whose program is loaded at runtime, not fixed at elaboration. Each core keeps its own private image.
- Has a synchronous-read fetch port with one-cycle latency, and a streaming program-load port (valid/ready) driven by the host/NoC loader.
- Provides a core-hold output so the core stalls while its program is being replaced.

Parameters:
- ADDR_W, 7, word-address width; DEPTH = 2**ADDR_W words (default 128).
- NODE_ID, 0, node index; reported on ld_node_id for loader bookkeeping.
- INIT_HALT, 1, 1 = hold the core from reset until the first load completes; 0 = core runs from reset.
- NOP_WORD, 32'h00000013, word returned on faulting fetches.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  in  1  fetch request.
- imem_addr  in  32  fetch byte address.
- imem_rdata  out  32  fetched instruction.
- imem_valid  out  1  imem_rdata valid; one-cycle pulse per served request.
- imem_err  out  1  with imem_valid: address was misaligned or out of range.
- core_hold  out  1  core must stall the PC and not retire.
- ld_start  in  1  begin a load (one-cycle pulse).
- ld_base  in  ADDR_W  first word address to write.
- ld_len  in  ADDR_W+1  number of words to write; 0..DEPTH.
- ld_valid  in  1  ld_data valid.
- ld_data  in  32  program word.
- ld_ready  out  1  block accepts ld_data this cycle.
- ld_done  out  1  one-cycle pulse when a load completes.
- ld_node_id  out  8  constant NODE_ID.

Behaviour:
- Reset values (asynchronous):
  - FSM = RUN.
  - imem_valid, imem_err, imem_rdata, ld_ready, ld_done = 0.
  - core_hold = INIT_HALT; booted flag = 0.
  - Word pointer and count = 0.
  - Memory contents are not reset.
- FSM states:
  - RUN → LOAD on ld_start with ld_len != 0. Latch ptr = ld_base and rem = ld_len.
  - ld_start with ld_len == 0: ld_done pulses the next cycle and the FSM stays in RUN; booted is set.
  - LOAD: ld_ready = 1 and core_hold = 1. Each ld_valid & ld_ready writes mem[ptr] = ld_data, then ptr = ptr+1 modulo DEPTH (wraps past DEPTH-1 to 0), and rem decrements.
  - LOAD → RUN on the cycle the last word is accepted (rem == 1). ld_done pulses the following cycle; booted is set.
  - ld_start while in LOAD is ignored.
  - ld_len > DEPTH is clamped to DEPTH.
- core_hold:
  - 1 in LOAD.
  - 1 in RUN while INIT_HALT && !booted.
  - Otherwise 0.
  - Deasserts the same cycle ld_done pulses.
- Fetch:
  - A request in RUN at cycle N gives imem_valid = 1 at N+1 with imem_rdata = mem[imem_addr[ADDR_W+1:2]].
  - Back-to-back requests are served every cycle.
  - Requests while in LOAD are dropped: imem_valid stays 0.
  - A request in the same cycle as an accepted ld_start is still served from the pre-load contents.
  - Fault when imem_addr[1:0] != 0 or imem_addr[31:ADDR_W+2] != 0: imem_valid = 1, imem_err = 1, imem_rdata = NOP_WORD, and no memory read.
  - imem_rdata holds its last value when imem_valid = 0.
- Read/write collision cannot occur: fetches are blocked in LOAD. Memory is single write port, single read port.
- Reset mid-load:
  - Returns to RUN immediately with no ld_done.
  - Words already written are kept.
  - booted is cleared, so with INIT_HALT = 1 the core is held again.

Decomposition:
- Package sm_imem_pkg:
  - FSM state enum {RUN, LOAD}.
  - NOP constant.
  - Width of ld_node_id (8).
- One sub-module, sm_imem_ram: DEPTH x 32 memory with a synchronous write port and a registered synchronous read port, no reset. Maps to FPGA block RAM.
- FSM, counters, fault decode and hold logic stay in sm_imem.

Test Plan:
- Reset with INIT_HALT = 1 → core_hold = 1. Fetch at addr 0 → imem_valid = 1. core_hold stays 1 until a load completes.
- Load base 0, len 5, words 61400293, 08000313, 00532023, 00032383, 00000063 (ld_valid stalled 2 cycles mid-stream) → ld_done one cycle after the 5th accept, then core_hold = 0. Fetch addr 0x0C → next cycle imem_rdata = 00032383.
- Load base 126, len 4 with ADDR_W = 7, words A, B, C, D → mem[126] = A, mem[127] = B, mem[0] = C, mem[1] = D (wrap-around).
- Fetch 0x202 (misaligned) and 0x200 (out of range) → imem_valid = 1, imem_err = 1, rdata = 00000013 for each.
- ld_start with len 0 → ld_done one cycle later, no writes, ld_ready never set. A second ld_start during a len-8 load is ignored, so exactly 8 words are written.
- Assert rst_n = 0 after 3 of 6 words → ld_ready = 0 immediately and no ld_done. Words 0..2 are retained (readable after a len-0 load releases the hold).
